// File: rtl/array_cmd_issuer.sv
// ============================================================================
// Module   : array_cmd_issuer
// Brief    : Queues host instructions, issues them to the array with a start
//            pulse, waits out execution and optionally sweeps PE readback.
// Revision : 1.0
// ============================================================================
`default_nettype none

module array_cmd_issuer #(
    parameter int SIZE        = 5,
    parameter int LENGTH      = 32,
    parameter int DEPTH       = 4,
    parameter int EXEC_CYCLES = 16,
    parameter int RD_LAT      = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [31:0]     cmd_instr,
    input  logic            cmd_rb_en,
    input  logic [9:0]      cmd_rb_reg,
    output logic [31:0]     instruction,
    output logic            start,
    output logic [SIZE-1:0] PE_Addr,
    output logic [9:0]      RegAddr,
    input  logic [15:0]     data,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [15:0]     rsp_data,
    output logic [SIZE-1:0] rsp_pe,
    output logic            rsp_last,
    output logic            busy
);

    localparam int c_PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W     = $clog2(DEPTH + 1);
    localparam int c_EXEC_EFF  = (EXEC_CYCLES < 1) ? 1 : EXEC_CYCLES;
    localparam int c_EXEC_W    = (c_EXEC_EFF > 1) ? $clog2(c_EXEC_EFF) : 1;

    localparam logic [c_PTR_W-1:0]  c_PTR_LAST  = c_PTR_W'(DEPTH - 1);
    localparam logic [c_PTR_W-1:0]  c_PTR_ONE   = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0]  c_CNT_FULL  = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_EXEC_W-1:0] c_EXEC_LOAD = c_EXEC_W'(c_EXEC_EFF - 1);
    localparam logic [c_EXEC_W-1:0] c_EXEC_ONE  = c_EXEC_W'(1);
    localparam logic [1:0]          c_RD_LAT    = 2'(RD_LAT);
    localparam logic [SIZE-1:0]     c_LAST_IDX  = SIZE'(LENGTH - 1);
    localparam logic [SIZE-1:0]     c_IDX_ONE   = SIZE'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_EXEC    = 3'd2,
        S_RB_SET  = 3'd3,
        S_RB_WAIT = 3'd4,
        S_RB_OUT  = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // Command queue
    // ------------------------------------------------------------------
    logic [31:0]        r_q_instr  [DEPTH];
    logic               r_q_rb_en  [DEPTH];
    logic [9:0]         r_q_rb_reg [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic w_push;
    logic w_pop;

    assign cmd_ready = (r_count != c_CNT_FULL);
    assign w_push    = cmd_valid && cmd_ready;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_instr[r_wr_ptr]  <= cmd_instr;
            r_q_rb_en[r_wr_ptr]  <= cmd_rb_en;
            r_q_rb_reg[r_wr_ptr] <= cmd_rb_reg;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    state_t              r_state;
    state_t              w_next;
    logic [c_EXEC_W-1:0] r_exec_cnt;
    logic [1:0]          r_wait_cnt;
    logic                r_rb_en;
    logic [9:0]          r_rb_reg;
    logic [SIZE-1:0]     r_idx;
    logic [31:0]         r_instr;
    logic [SIZE-1:0]     r_pe_addr;
    logic [9:0]          r_reg_addr;
    logic                r_rsp_valid;
    logic [15:0]         r_rsp_data;
    logic [SIZE-1:0]     r_rsp_pe;
    logic                r_rsp_last;

    logic w_enter_rb;
    logic w_capture;
    logic w_rsp_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_pop      = 1'b0;
        w_enter_rb = 1'b0;
        w_capture  = 1'b0;
        w_rsp_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_pop  = 1'b1;
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_next = S_EXEC;
            end
            S_EXEC: begin
                if (r_exec_cnt == '0) begin
                    w_enter_rb = r_rb_en;
                    w_next     = r_rb_en ? S_RB_SET : S_IDLE;
                end
            end
            S_RB_SET: begin
                // Zero read latency: data already reflects the address driven on entry.
                if (c_RD_LAT == 2'd0) begin
                    w_capture = 1'b1;
                    w_next    = S_RB_OUT;
                end else begin
                    w_next = S_RB_WAIT;
                end
            end
            S_RB_WAIT: begin
                if (r_wait_cnt == 2'd0) begin
                    w_capture = 1'b1;
                    w_next    = S_RB_OUT;
                end
            end
            S_RB_OUT: begin
                if (rsp_ready) begin
                    w_rsp_done = 1'b1;
                    if (r_rsp_last) begin
                        w_next = S_IDLE;
                    end else begin
                        w_enter_rb = 1'b1;
                        w_next     = S_RB_SET;
                    end
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_instr     <= '0;
            r_rb_en     <= 1'b0;
            r_rb_reg    <= '0;
            r_exec_cnt  <= '0;
            r_wait_cnt  <= '0;
            r_idx       <= '0;
            r_pe_addr   <= '0;
            r_reg_addr  <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_pe    <= '0;
            r_rsp_last  <= 1'b0;
        end else begin
            if (w_pop) begin
                r_instr  <= r_q_instr[r_rd_ptr];
                r_rb_en  <= r_q_rb_en[r_rd_ptr];
                r_rb_reg <= r_q_rb_reg[r_rd_ptr];
            end

            if (r_state == S_ISSUE) begin
                r_exec_cnt <= c_EXEC_LOAD;
            end else if ((r_state == S_EXEC) && (r_exec_cnt != '0)) begin
                r_exec_cnt <= r_exec_cnt - c_EXEC_ONE;
            end

            if (r_state == S_RB_SET) begin
                r_wait_cnt <= c_RD_LAT;
            end else if ((r_state == S_RB_WAIT) && (r_wait_cnt != 2'd0)) begin
                r_wait_cnt <= r_wait_cnt - 2'd1;
            end

            // Address is driven on entry so the read latency counts from RB_SET.
            if (w_enter_rb) begin
                r_pe_addr  <= (r_state == S_EXEC) ? r_idx : r_idx + c_IDX_ONE;
                r_reg_addr <= r_rb_reg;
            end

            if (w_capture) begin
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= data;
                r_rsp_pe    <= r_idx;
                r_rsp_last  <= (r_idx == c_LAST_IDX);
            end else if (w_rsp_done) begin
                r_rsp_valid <= 1'b0;
                r_idx       <= r_rsp_last ? '0 : r_idx + c_IDX_ONE;
            end
        end
    end

    assign instruction = r_instr;
    assign start       = (r_state == S_ISSUE);
    assign PE_Addr     = r_pe_addr;
    assign RegAddr     = r_reg_addr;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_data    = r_rsp_data;
    assign rsp_pe      = r_rsp_pe;
    assign rsp_last    = r_rsp_last;
    assign busy        = (r_state != S_IDLE) || (r_count != '0);

endmodule

`default_nettype wire

// File: tb/tb_array_cmd_issuer.sv
// ============================================================================
// Module   : tb_array_cmd_issuer
// Brief    : Directed self-checking bench for array_cmd_issuer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_array_cmd_issuer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_instr;
    logic        cmd_rb_en;
    logic [9:0]  cmd_rb_reg;
    logic [31:0] instruction;
    logic        start;
    logic [4:0]  PE_Addr;
    logic [9:0]  RegAddr;
    logic [15:0] data;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [15:0] rsp_data;
    logic [4:0]  rsp_pe;
    logic        rsp_last;
    logic        busy;

    always #5 clk = ~clk;

    array_cmd_issuer #(
        .SIZE(5), .LENGTH(32), .DEPTH(4), .EXEC_CYCLES(16), .RD_LAT(1)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_instr(cmd_instr),
        .cmd_rb_en(cmd_rb_en), .cmd_rb_reg(cmd_rb_reg),
        .instruction(instruction), .start(start),
        .PE_Addr(PE_Addr), .RegAddr(RegAddr), .data(data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_pe(rsp_pe), .rsp_last(rsp_last), .busy(busy)
    );

    // Array model: one-cycle registered readback of {PE_Addr, RegAddr}
    always @(posedge clk) data <= {1'b0, PE_Addr, RegAddr};

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Response / start monitor
    logic [31:0] start_log[$];
    int          n_hs = 0;
    int          n_last = 0;
    int          n_valid_seen = 0;
    int          exp_idx = 0;
    logic [9:0]  exp_rb_reg = '0;

    always @(negedge clk) begin
        if (start) start_log.push_back(instruction);
        if (rsp_valid) begin
            n_valid_seen++;
            check("rsp_pe", 32'(rsp_pe), 32'(exp_idx));
            check("rsp_data", 32'(rsp_data), {16'h0, 1'b0, 5'(exp_idx), exp_rb_reg});
            check("rsp_last", 32'(rsp_last), 32'(exp_idx == 31));
            check("start_during_rsp", 32'(start), 32'd0);
            if (rsp_ready) begin
                n_hs++;
                if (rsp_last) n_last++;
                exp_idx = (exp_idx == 31) ? 0 : exp_idx + 1;
            end
        end
    end

    bit toggle_mode = 1'b0;
    int ph = 0;
    always @(posedge clk) begin
        #1;
        if (toggle_mode) begin
            ph++;
            rsp_ready = ((ph / 3) % 2) == 1;
        end else begin
            rsp_ready = 1'b1;
        end
    end

    task automatic wait_start(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!start && n < 60);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 3000) begin
            tick();
            n++;
        end
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    typedef struct {
        logic [31:0] instr;
        logic        rb_en;
        logic [9:0]  rb_reg;
        int          exp_busy;   // cycles from start to busy falling
        int          exp_hs;
        int          exp_last;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int n;
        int m;
        int k;
        int hs0;
        int last0;
        int seen0;
        int log0;
        logic rdy;
        logic [31:0] q_exp[6];

        vecs[0] = '{32'h00241800, 1'b0, 10'h000, 17, 0, 0};
        vecs[1] = '{32'hDEADBEEF, 1'b0, 10'h3FF, 17, 0, 0};
        vecs[2] = '{32'h12345678, 1'b1, 10'h020, 145, 32, 1};
        vecs[3] = '{32'hA5A50001, 1'b1, 10'h3FF, 145, 32, 1};

        // Reset held with a command offered
        reset      = 1'b0;
        cmd_valid  = 1'b1;
        cmd_instr  = 32'h11110000;
        cmd_rb_en  = 1'b0;
        cmd_rb_reg = '0;
        repeat (3) tick();
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_start", 32'(start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_instruction", instruction, 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_pe_addr", 32'(PE_Addr), 32'd0);

        reset = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("busy_after_first_push", 32'(busy), 32'd1);
        wait_start(n);
        check("first_start_latency", 32'(n + 1), 32'd2);
        check("first_instruction", instruction, 32'h11110000);
        wait_idle(m);

        // Table-driven single commands
        for (int i = 0; i < 4; i++) begin
            exp_rb_reg = vecs[i].rb_reg;
            hs0        = n_hs;
            last0      = n_last;
            cmd_instr  = vecs[i].instr;
            cmd_rb_en  = vecs[i].rb_en;
            cmd_rb_reg = vecs[i].rb_reg;
            cmd_valid  = 1'b1;
            tick();
            cmd_valid = 1'b0;
            wait_start(n);
            check("start_latency", 32'(n + 1), 32'd2);
            check("issued_instruction", instruction, vecs[i].instr);
            tick();
            check("start_one_cycle", 32'(start), 32'd0);
            wait_idle(m);
            check("busy_fall", 32'(m + 1), 32'(vecs[i].exp_busy));
            check("handshakes", 32'(n_hs - hs0), 32'(vecs[i].exp_hs));
            check("last_count", 32'(n_last - last0), 32'(vecs[i].exp_last));
            check("instruction_hold", instruction, vecs[i].instr);
        end

        // Readback with a stalling consumer
        toggle_mode = 1'b1;
        exp_rb_reg  = 10'h155;
        hs0         = n_hs;
        last0       = n_last;
        cmd_instr   = 32'h0BADF00D;
        cmd_rb_en   = 1'b1;
        cmd_rb_reg  = 10'h155;
        cmd_valid   = 1'b1;
        tick();
        cmd_valid = 1'b0;
        wait_idle(m);
        check("stall_handshakes", 32'(n_hs - hs0), 32'd32);
        check("stall_last_count", 32'(n_last - last0), 32'd1);
        check("stall_idx_wrapped", 32'(exp_idx), 32'd0);
        toggle_mode = 1'b0;

        // Queue fill while stalled in EXEC
        start_log.delete();
        q_exp = '{32'hA0000000, 32'hB0000001, 32'hC0000002,
                  32'hD0000003, 32'hE0000004, 32'hF0000005};
        cmd_rb_en = 1'b0;
        cmd_instr = q_exp[0];
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        wait_start(n);
        for (int i = 1; i < 5; i++) begin
            check("ready_before_push", 32'(cmd_ready), 32'd1);
            cmd_instr = q_exp[i];
            cmd_valid = 1'b1;
            tick();
        end
        cmd_valid = 1'b0;
        check("ready_when_full", 32'(cmd_ready), 32'd0);
        cmd_instr = q_exp[5];
        cmd_valid = 1'b1;
        k = 0;
        do begin
            rdy = cmd_ready;
            tick();
            k++;
        end while (!rdy && k < 100);
        cmd_valid = 1'b0;
        check("fifth_held", 32'(k > 1), 32'd1);
        check("fifth_after_pop", 32'(start_log.size()), 32'd2);
        wait_idle(m);
        check("issue_count", 32'(start_log.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            check("issue_order", (i < start_log.size()) ? start_log[i] : 32'hFFFFFFFF, q_exp[i]);
        end

        // Reset in the middle of a readback sweep
        exp_rb_reg = 10'h2AA;
        cmd_instr  = 32'h77777777;
        cmd_rb_en  = 1'b1;
        cmd_rb_reg = 10'h2AA;
        cmd_valid  = 1'b1;
        tick();
        cmd_valid = 1'b0;
        n = 0;
        while (!(rsp_valid && rsp_pe == 5'd7) && n < 500) begin
            tick();
            n++;
        end
        check("reached_pe7", 32'(rsp_valid && rsp_pe == 5'd7), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_instruction", instruction, 32'd0);
        check("arst_start", 32'(start), 32'd0);
        check("arst_pe_addr", 32'(PE_Addr), 32'd0);
        check("arst_reg_addr", 32'(RegAddr), 32'd0);
        check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("arst_rsp_data", 32'(rsp_data), 32'd0);
        check("arst_rsp_pe", 32'(rsp_pe), 32'd0);
        check("arst_rsp_last", 32'(rsp_last), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_cmd_ready", 32'(cmd_ready), 32'd1);
        exp_idx = 0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        seen0 = n_valid_seen;
        log0  = start_log.size();
        repeat (40) tick();
        check("post_rst_no_rsp", 32'(n_valid_seen - seen0), 32'd0);
        check("post_rst_no_start", 32'(start_log.size() - log0), 32'd0);
        check("post_rst_idle", 32'(busy), 32'd0);
        check("post_rst_ready", 32'(cmd_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
